rv32i_pipelined_cpu: RTL and testbench

//  Self-contained 5-stage in-order RV32I core (IF/ID/EX/MEM/WB) with private instruction and data memories.
//  Top of the processor hierarchy; only clock and reset cross the boundary.

---
 rtl/rv32i_pipelined_cpu.sv | 266 ++++++++++++++++++++++++++
 tb/tb_rv32i_pipelined_cpu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_pipelined_cpu.sv
// rv32i_pipelined_cpu: self-contained 5-stage in-order RV32I core (IF/ID/EX/MEM/WB)
// with a private instruction ROM and a private byte-addressed data RAM.
// Ports:
//   clk    - system clock, all state updates on the rising edge
//   reset  - asynchronous, active-low reset
// Observation points: pc (IF-stage PC), inst (IF-stage fetched word),
// reg_file.reg_file[0:31] (architectural registers, x10 = result register).

// Register file: two combinational read ports with write-through bypass,
// one write port. x0 reads as zero and ignores writes.
module rv32i_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      reg_file[waddr] <= wdata;
    end
  end

  // A read of the register being written this cycle sees the new value.
  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : (we && waddr == raddr1) ? wdata : reg_file[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : (we && waddr == raddr2) ? wdata : reg_file[raddr2];
endmodule

module rv32i_pipelined_cpu #(
  parameter int    IMEM_WORDS = 1024,
  parameter int    DMEM_WORDS = 1024,
  parameter string IMEM_FILE  = "program.hex"
) (
  input logic clk,
  input logic reset
);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam int          IMEM_AW = $clog2(IMEM_WORDS);
  localparam int          DMEM_AW = $clog2(DMEM_WORDS);
  localparam logic [6:0]  OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                          OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23,
                          OP_IMM = 7'h13, OP_REG = 7'h33;

  // True when the instruction produces a register result (rd != x0).
  function automatic logic writes_rd(input logic [31:0] i);
    case (i[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG: writes_rd = (i[11:7] != 5'd0);
      default: writes_rd = 1'b0;
    endcase
  endfunction

  // ---------------- IF ----------------
  logic [31:0] pc, inst;
  logic [31:0] imem [0:IMEM_WORDS-1];

  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = NOP;
  end

  always_comb begin
    inst = NOP;
    if (pc[31:2] < 30'(IMEM_WORDS)) inst = imem[pc[IMEM_AW+1:2]];
  end

  // ---------------- pipeline registers ----------------
  logic        if_id_valid, id_ex_valid, ex_mem_valid, mem_wb_valid;
  logic [31:0] if_id_pc, if_id_inst;
  logic [31:0] id_ex_pc, id_ex_inst, id_ex_imm, id_ex_rs1_val, id_ex_rs2_val;
  logic [31:0] ex_mem_inst, ex_mem_result, ex_mem_wdata;
  logic [31:0] mem_wb_inst, mem_wb_data;

  // ---------------- ID ----------------
  logic [6:0]  id_op;
  logic [31:0] id_imm, id_rs1_val, id_rs2_val;
  logic        id_uses_rs1, id_uses_rs2, stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  assign id_op = if_id_inst[6:0];

  always_comb begin
    case (id_op)
      OP_LUI, OP_AUIPC: id_imm = {if_id_inst[31:12], 12'd0};
      OP_JAL:    id_imm = {{11{if_id_inst[31]}}, if_id_inst[31], if_id_inst[19:12],
                           if_id_inst[20], if_id_inst[30:21], 1'b0};
      OP_BRANCH: id_imm = {{19{if_id_inst[31]}}, if_id_inst[31], if_id_inst[7],
                           if_id_inst[30:25], if_id_inst[11:8], 1'b0};
      OP_STORE:  id_imm = {{20{if_id_inst[31]}}, if_id_inst[31:25], if_id_inst[11:7]};
      default:   id_imm = {{20{if_id_inst[31]}}, if_id_inst[31:20]};
    endcase
  end

  rv32i_regfile reg_file (
    .clk(clk), .rst_n(reset), .we(rf_we), .waddr(rf_waddr), .wdata(rf_wdata),
    .raddr1(if_id_inst[19:15]), .raddr2(if_id_inst[24:20]),
    .rdata1(id_rs1_val), .rdata2(id_rs2_val)
  );

  // Load-use: a load in EX whose rd is sourced by the ID instruction cannot be
  // forwarded in time, so hold IF/ID for one cycle and let a bubble into EX.
  assign id_uses_rs1 = if_id_valid && (id_op == OP_JALR || id_op == OP_BRANCH || id_op == OP_LOAD ||
                                       id_op == OP_STORE || id_op == OP_IMM || id_op == OP_REG);
  assign id_uses_rs2 = if_id_valid && (id_op == OP_BRANCH || id_op == OP_STORE || id_op == OP_REG);
  assign stall = id_ex_valid && id_ex_inst[6:0] == OP_LOAD && id_ex_inst[11:7] != 5'd0 &&
                 ((id_uses_rs1 && if_id_inst[19:15] == id_ex_inst[11:7]) ||
                  (id_uses_rs2 && if_id_inst[24:20] == id_ex_inst[11:7]));

  // ---------------- EX ----------------
  logic [6:0]  ex_op;
  logic [2:0]  ex_f3;
  logic [31:0] ex_a, ex_b, alu_b, alu_out, ex_result, ex_target;
  logic        br_cond, ex_taken;

  assign ex_op = id_ex_inst[6:0];
  assign ex_f3 = id_ex_inst[14:12];

  // Forwarding: MEM/WB first, then EX/MEM overrides so the youngest result wins.
  always_comb begin
    ex_a = id_ex_rs1_val;
    ex_b = id_ex_rs2_val;
    if (mem_wb_valid && writes_rd(mem_wb_inst) && mem_wb_inst[11:7] == id_ex_inst[19:15]) ex_a = mem_wb_data;
    if (mem_wb_valid && writes_rd(mem_wb_inst) && mem_wb_inst[11:7] == id_ex_inst[24:20]) ex_b = mem_wb_data;
    if (ex_mem_valid && writes_rd(ex_mem_inst) && ex_mem_inst[11:7] == id_ex_inst[19:15]) ex_a = ex_mem_result;
    if (ex_mem_valid && writes_rd(ex_mem_inst) && ex_mem_inst[11:7] == id_ex_inst[24:20]) ex_b = ex_mem_result;
  end

  assign alu_b = (ex_op == OP_REG) ? ex_b : id_ex_imm;

  always_comb begin
    case (ex_f3)
      3'b000:  alu_out = (ex_op == OP_REG && id_ex_inst[30]) ? ex_a - alu_b : ex_a + alu_b;
      3'b001:  alu_out = ex_a << alu_b[4:0];
      3'b010:  alu_out = {31'd0, $signed(ex_a) < $signed(alu_b)};
      3'b011:  alu_out = {31'd0, ex_a < alu_b};
      3'b100:  alu_out = ex_a ^ alu_b;
      3'b101:  alu_out = id_ex_inst[30] ? 32'($signed(ex_a) >>> alu_b[4:0]) : ex_a >> alu_b[4:0];
      3'b110:  alu_out = ex_a | alu_b;
      default: alu_out = ex_a & alu_b;
    endcase
  end

  always_comb begin
    case (ex_f3)
      3'b000:  br_cond = (ex_a == ex_b);
      3'b001:  br_cond = (ex_a != ex_b);
      3'b100:  br_cond = ($signed(ex_a) < $signed(ex_b));
      3'b101:  br_cond = ($signed(ex_a) >= $signed(ex_b));
      3'b110:  br_cond = (ex_a < ex_b);
      3'b111:  br_cond = (ex_a >= ex_b);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    case (ex_op)
      OP_LUI:          ex_result = id_ex_imm;
      OP_AUIPC:        ex_result = id_ex_pc + id_ex_imm;
      OP_JAL, OP_JALR: ex_result = id_ex_pc + 32'd4;
      OP_IMM, OP_REG:  ex_result = alu_out;
      default:         ex_result = ex_a + id_ex_imm;  // load/store effective address
    endcase
  end

  assign ex_target = (ex_op == OP_JALR) ? ((ex_a + id_ex_imm) & ~32'd1) : (id_ex_pc + id_ex_imm);
  assign ex_taken  = id_ex_valid && (ex_op == OP_JAL || ex_op == OP_JALR || (ex_op == OP_BRANCH && br_cond));

  // ---------------- MEM ----------------
  logic [31:0]        dmem [0:DMEM_WORDS-1];
  logic [DMEM_AW-1:0] mem_idx;
  logic [31:0]        mem_rword, mem_byte, mem_data, mem_wdata_sh;
  logic [15:0]        mem_half;
  logic [3:0]         mem_be;
  logic               mem_we;

  // Sub-word accesses are aligned down to their natural size (addr & ~(size-1)).
  assign mem_idx   = ex_mem_result[DMEM_AW+1:2];
  assign mem_rword = dmem[mem_idx];
  assign mem_byte  = mem_rword >> {ex_mem_result[1:0], 3'b000};
  assign mem_half  = ex_mem_result[1] ? mem_rword[31:16] : mem_rword[15:0];
  assign mem_we    = ex_mem_valid && ex_mem_inst[6:0] == OP_STORE;

  always_comb begin
    mem_data = ex_mem_result;
    if (ex_mem_inst[6:0] == OP_LOAD) begin
      case (ex_mem_inst[14:12])
        3'b000:  mem_data = {{24{mem_byte[7]}}, mem_byte[7:0]};
        3'b001:  mem_data = {{16{mem_half[15]}}, mem_half};
        3'b100:  mem_data = {24'd0, mem_byte[7:0]};
        3'b101:  mem_data = {16'd0, mem_half};
        default: mem_data = mem_rword;
      endcase
    end
  end

  always_comb begin
    case (ex_mem_inst[13:12])
      2'b00:   begin mem_be = 4'b0001 << ex_mem_result[1:0];           mem_wdata_sh = {4{ex_mem_wdata[7:0]}}; end
      2'b01:   begin mem_be = ex_mem_result[1] ? 4'b1100 : 4'b0011;    mem_wdata_sh = {2{ex_mem_wdata[15:0]}}; end
      default: begin mem_be = 4'b1111;                                 mem_wdata_sh = ex_mem_wdata; end
    endcase
  end

  // Data RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) dmem[mem_idx][8*b +: 8] <= mem_wdata_sh[8*b +: 8];
      end
    end
  end

  // ---------------- WB ----------------
  assign rf_we    = mem_wb_valid && writes_rd(mem_wb_inst);
  assign rf_waddr = mem_wb_inst[11:7];
  assign rf_wdata = mem_wb_data;

  // ---------------- sequential pipeline ----------------
  // A redirect squashes IF/ID and ID/EX, which also overrides a concurrent stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc            <= '0;
      if_id_valid   <= 1'b0; if_id_pc <= '0; if_id_inst <= NOP;
      id_ex_valid   <= 1'b0; id_ex_pc <= '0; id_ex_inst <= NOP;
      id_ex_imm     <= '0;   id_ex_rs1_val <= '0; id_ex_rs2_val <= '0;
      ex_mem_valid  <= 1'b0; ex_mem_inst <= NOP; ex_mem_result <= '0; ex_mem_wdata <= '0;
      mem_wb_valid  <= 1'b0; mem_wb_inst <= NOP; mem_wb_data <= '0;
    end else begin
      if (ex_taken)    pc <= ex_target;
      else if (!stall) pc <= pc + 32'd4;

      if (ex_taken) begin
        if_id_valid <= 1'b0; if_id_inst <= NOP;
      end else if (!stall) begin
        if_id_valid <= 1'b1; if_id_pc <= pc; if_id_inst <= inst;
      end

      if (ex_taken || stall) begin
        id_ex_valid <= 1'b0; id_ex_inst <= NOP;
      end else begin
        id_ex_valid   <= if_id_valid; id_ex_pc <= if_id_pc; id_ex_inst <= if_id_inst;
        id_ex_imm     <= id_imm;
        id_ex_rs1_val <= id_rs1_val;  id_ex_rs2_val <= id_rs2_val;
      end

      ex_mem_valid  <= id_ex_valid;  ex_mem_inst <= id_ex_inst;
      ex_mem_result <= ex_result;    ex_mem_wdata <= ex_b;

      mem_wb_valid  <= ex_mem_valid; mem_wb_inst <= ex_mem_inst;
      mem_wb_data   <= mem_data;
    end
  end

  // Instruction fields that no later stage needs.
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], id_ex_inst[31], id_ex_inst[29:25], ex_mem_inst[31:15],
                         mem_wb_inst[31:12]};
endmodule

// File: tb/tb_rv32i_pipelined_cpu.sv
// Bench for rv32i_pipelined_cpu: loads small hand-assembled programs into the
// instruction ROM, and checks every write to x10 against a queue of
// hand-computed values, plus reset, pc-trace and halt-spin checks.
module tb_rv32i_pipelined_cpu;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk, reset;
  int   checks, failures;
  logic mon_en;
  string cur_name;
  logic [31:0] exp_q[$];
  logic [31:0] prog[$];
  logic [31:0] mon_exp;

  rv32i_pipelined_cpu #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .IMEM_FILE("")) dut (
    .clk(clk), .reset(reset)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] im, a, f, d, o;
    im = imm; a = rs1; f = f3; d = rd; o = op;
    return {im[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] s, b, a, f, d;
    s = f7; b = rs2; a = rs1; f = f3; d = rd;
    return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, b, a, f;
    im = imm; b = rs2; a = rs1; f = f3;
    return {im[11:5], b[4:0], a[4:0], f[2:0], im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, b, a, f;
    im = imm; b = rs2; a = rs1; f = f3;
    return {im[12], im[10:5], b[4:0], a[4:0], f[2:0], im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input int imm20, input int rd, input int op);
    logic [31:0] im, d, o;
    im = imm20; d = rd; o = op;
    return {im[19:0], d[4:0], o[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_prog(input string name, input logic monitor_on);
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b0;
    cur_name = name;
    for (int i = 0; i < 1024; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : NOP;
    @(negedge clk);
    mon_en = monitor_on;
    reset  = 1'b1;
  endtask

  task automatic finish_prog();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    check({cur_name, "_pending_a0_writes"}, 32'(exp_q.size()), 32'd0);
    repeat (8) @(negedge clk);
  endtask

  task automatic sum_loop_prog();
    prog.delete();
    prog.push_back(addi(10, 0, 0));
    prog.push_back(addi(11, 0, 1));
    prog.push_back(addi(12, 0, 11));
    prog.push_back(enc_r(0, 11, 10, 0, 10));   // ADD x10,x10,x11
    prog.push_back(addi(11, 11, 1));
    prog.push_back(enc_b(-8, 12, 11, 1));      // BNE x11,x12,-8
    prog.push_back(enc_j(0, 0));               // JAL x0,0
  endtask

  task automatic push_sum_expect();
    exp_q.push_back(32'd0);
    for (int k = 1; k <= 10; k++) exp_q.push_back(32'(k * (k + 1) / 2));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en && reset && dut.rf_we && dut.rf_waddr == 5'd10) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL %s_a0_extra_write actual=%h expected=no write", cur_name, dut.rf_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        check({cur_name, "_a0_write"}, dut.rf_wdata, mon_exp);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clk = 1'b0; reset = 1'b1; mon_en = 1'b0; checks = 0; failures = 0; cur_name = "init";
    #3 reset = 1'b0;
    #1;
    check("reset_pc", dut.pc, 32'd0);
    check("reset_x10", dut.reg_file.reg_file[10], 32'd0);
    check("reset_if_id_valid", {31'd0, dut.if_id_valid}, 32'd0);

    // Back-to-back EX->EX forwarding.
    prog.delete();
    prog.push_back(addi(10, 0, 5));
    prog.push_back(addi(10, 10, 7));
    prog.push_back(enc_j(0, 0));
    exp_q.push_back(32'd5); exp_q.push_back(32'd12);
    start_prog("fwd", 1'b1);
    finish_prog();

    // Store then load-use stall.
    prog.delete();
    prog.push_back(enc_u('hDEADC, 6, 'h37));
    prog.push_back(addi(6, 6, -273));
    prog.push_back(enc_s(0, 6, 0, 2));         // SW x6,0(x0)
    prog.push_back(enc_i(0, 0, 2, 5, 'h03));   // LW x5,0(x0)
    prog.push_back(enc_r(0, 0, 5, 0, 10));     // ADD x10,x5,x0
    prog.push_back(enc_j(0, 0));
    exp_q.push_back(32'hDEADBEEF);
    start_prog("loaduse", 1'b1);
    finish_prog();

    // Taken branch squashes the two following writes.
    prog.delete();
    prog.push_back(addi(10, 0, 1));
    prog.push_back(addi(11, 0, 0));
    prog.push_back(enc_b(12, 0, 0, 0));        // BEQ x0,x0,+12 at 0x8
    prog.push_back(addi(10, 0, 2));
    prog.push_back(addi(10, 0, 3));
    prog.push_back(addi(10, 10, 16));          // 0x14
    prog.push_back(enc_j(0, 0));
    exp_q.push_back(32'd1); exp_q.push_back(32'd17);
    start_prog("branch", 1'b1);
    check("branch_pc_after_reset", dut.pc, 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("branch_pc_trace", dut.pc, 32'(4 * k));
    end
    finish_prog();

    // Sum 1..10 with a BNE back-edge, then spin on JAL x0,0 at 0x18.
    sum_loop_prog();
    push_sum_expect();
    start_prog("sumloop", 1'b1);
    finish_prog();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("sumloop_spin_pc", {31'd0, (dut.pc >= 32'h18 && dut.pc <= 32'h20)}, 32'd1);
    end

    // Byte/halfword stores and sign/zero-extending loads.
    prog.delete();
    prog.push_back(enc_u('h11223, 6, 'h37));
    prog.push_back(addi(6, 6, 'h344));
    prog.push_back(enc_s(0, 6, 0, 2));         // SW  x6,0(x0)
    prog.push_back(addi(7, 0, 'h80));
    prog.push_back(enc_s(1, 7, 0, 0));         // SB  x7,1(x0)
    prog.push_back(enc_i(1, 0, 0, 10, 'h03));  // LB  x10,1(x0)
    prog.push_back(enc_i(1, 0, 4, 10, 'h03));  // LBU x10,1(x0)
    prog.push_back(enc_i(0, 0, 2, 10, 'h03));  // LW  x10,0(x0)
    prog.push_back(enc_i(2, 0, 1, 10, 'h03));  // LH  x10,2(x0)
    prog.push_back(enc_s(2, 7, 0, 1));         // SH  x7,2(x0)
    prog.push_back(enc_i(0, 0, 2, 10, 'h03));  // LW  x10,0(x0)
    prog.push_back(enc_i(1, 0, 5, 10, 'h03));  // LHU x10,1(x0) -> aligned to 0
    prog.push_back(enc_i(0, 0, 1, 10, 'h03));  // LH  x10,0(x0)
    prog.push_back(enc_j(0, 0));
    exp_q.push_back(32'hFFFFFF80); exp_q.push_back(32'h00000080);
    exp_q.push_back(32'h11228044); exp_q.push_back(32'h00001122);
    exp_q.push_back(32'h00808044); exp_q.push_back(32'h00008044);
    exp_q.push_back(32'hFFFF8044);
    start_prog("bytes", 1'b1);
    finish_prog();

    // ALU mix, AUIPC, JAL/JALR link values, taken and not-taken branches.
    prog.delete();
    prog.push_back(addi(1, 0, -1));
    prog.push_back(addi(2, 0, 1));
    prog.push_back(enc_r(0, 2, 1, 2, 10));       // SLT  x10,x1,x2
    prog.push_back(enc_r(0, 2, 1, 3, 10));       // SLTU x10,x1,x2
    prog.push_back(enc_i('h404, 1, 5, 10, 'h13)); // SRAI x10,x1,4
    prog.push_back(enc_i(28, 1, 5, 10, 'h13));   // SRLI x10,x1,28
    prog.push_back(enc_r('h20, 1, 2, 0, 10));    // SUB  x10,x2,x1
    prog.push_back(addi(3, 0, 33));
    prog.push_back(enc_r(0, 3, 2, 1, 10));       // SLL  x10,x2,x3 (shift 1)
    prog.push_back(enc_i('hF0, 1, 4, 10, 'h13)); // XORI x10,x1,0xF0
    prog.push_back(enc_u(1, 10, 'h17));          // AUIPC x10,1 at 0x28
    prog.push_back(enc_j(8, 10));                // JAL x10,+8 at 0x2C
    prog.push_back(addi(10, 0, 99));
    prog.push_back(enc_i('h41, 0, 0, 10, 'h67)); // JALR x10,0x41(x0) at 0x34
    prog.push_back(addi(10, 0, 98));
    prog.push_back(addi(10, 0, 97));
    prog.push_back(enc_b(8, 2, 1, 4));           // BLT  x1,x2,+8 at 0x40
    prog.push_back(addi(10, 0, 96));
    prog.push_back(enc_b(8, 2, 1, 7));           // BGEU x1,x2,+8 at 0x48
    prog.push_back(addi(10, 0, 95));
    prog.push_back(enc_b(8, 2, 1, 5));           // BGE  x1,x2,+8 not taken
    prog.push_back(addi(10, 0, 7));
    prog.push_back(enc_j(0, 0));
    exp_q.push_back(32'd1);          exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFFFFFF);   exp_q.push_back(32'h0000000F);
    exp_q.push_back(32'd2);          exp_q.push_back(32'd2);
    exp_q.push_back(32'hFFFFFF0F);   exp_q.push_back(32'h00001028);
    exp_q.push_back(32'h00000030);   exp_q.push_back(32'h00000038);
    exp_q.push_back(32'd7);
    start_prog("alu", 1'b1);
    finish_prog();

    // Reset asserted mid-run, then a clean restart from address 0.
    sum_loop_prog();
    exp_q.delete();
    start_prog("midreset", 1'b0);
    repeat (30) @(negedge clk);
    check("midreset_x10_progress", {31'd0, (dut.reg_file.reg_file[10] != 32'd0)}, 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_pc", dut.pc, 32'd0);
    check("midreset_x10", dut.reg_file.reg_file[10], 32'd0);
    check("midreset_id_ex_valid", {31'd0, dut.id_ex_valid}, 32'd0);
    push_sum_expect();
    @(negedge clk);
    mon_en = 1'b1;
    reset  = 1'b1;
    finish_prog();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
